// File: rtl/bist_pkg.sv
// Shared types and constants for the adder BIST controller and its LFSR.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned LFSR_W      = 17;
  localparam int unsigned LFSR_TAP_HI = 16;
  localparam int unsigned LFSR_TAP_LO = 13;

  localparam logic [15:0] NO_FAIL = 16'hFFFF;

  // Directed corner vectors packed as {A, B, Cin}; entry 0 is issued first.
  localparam logic [3:0][LFSR_W-1:0] DIRECTED_VEC = {
    {8'h00, 8'h00, 1'b0},
    {8'hFF, 8'hFF, 1'b1},
    {8'hFF, 8'hFF, 1'b0},
    {8'hFF, 8'h01, 1'b0}
  };

  function automatic logic [8:0] golden_add(input logic [7:0] a, input logic [7:0] b,
                                            input logic cin);
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

endpackage

// File: rtl/bist_lfsr17.sv
// 17-bit Fibonacci LFSR (x^17 + x^14 + 1) with seed load and advance enable.
module bist_lfsr17
  import bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 17'h1ACE5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_adv,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb    = r_q[LFSR_TAP_HI] ^ r_q[LFSR_TAP_LO];
  assign o_state = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= SEED;
    end else if (i_adv) begin
      r_q <= {r_q[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/adder_bist.sv
// BIST controller for the 8-bit adder: issues directed then LFSR vectors,
// checks each result against a delayed golden sum and reports the verdict.
module adder_bist
  import bist_pkg::*;
#(
  parameter int unsigned       NUM_VECTORS = 256,
  parameter int unsigned       DUT_LATENCY = 0,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 17'h1ACE5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  dut_a,
  output logic [7:0]  dut_b,
  output logic        dut_cin,
  input  logic [7:0]  dut_sum,
  input  logic        dut_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx
);

  localparam int unsigned DEPTH = DUT_LATENCY + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_idx;
  logic [7:0]        r_dut_a;
  logic [7:0]        r_dut_b;
  logic              r_dut_cin;
  logic [15:0]       r_err;
  logic [15:0]       r_ffi;

  logic [LFSR_W-1:0] w_lfsr;
  logic [LFSR_W-1:0] w_vec;
  logic [15:0]       w_k;
  logic [8:0]        w_exp;
  logic              w_accept;
  logic              w_run;
  logic              w_issue;
  logic              w_last;
  logic              w_pipe_busy;
  logic              w_mis;

  // Expected result and vector index travel alongside the adder's pipeline.
  logic              r_pv [DEPTH];
  logic [15:0]       r_pk [DEPTH];
  logic [8:0]        r_pe [DEPTH];

  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_run    = (r_state == ST_RUN);
  assign w_issue  = w_accept || w_run;
  assign w_last   = w_run && (r_idx == 16'(NUM_VECTORS - 1));
  assign w_k      = w_run ? r_idx : '0;

  bist_lfsr17 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_adv   (w_run && (r_idx >= 16'd4)),
    .o_state (w_lfsr)
  );

  always_comb begin
    w_vec = DIRECTED_VEC[0];
    if (w_run) begin
      if (r_idx < 16'd4) begin
        w_vec = DIRECTED_VEC[r_idx[1:0]];
      end else begin
        w_vec = w_lfsr;
      end
    end
  end

  assign w_exp = golden_add(w_vec[16:9], w_vec[8:1], w_vec[0]);

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_pipe_busy = w_pipe_busy | r_pv[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!w_pipe_busy) w_state_nxt = ST_DONE;
      ST_DONE:  if (start) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_dut_a   <= '0;
      r_dut_b   <= '0;
      r_dut_cin <= 1'b0;
    end else if (w_issue) begin
      r_idx     <= w_accept ? 16'd1 : r_idx + 16'd1;
      r_dut_a   <= w_vec[16:9];
      r_dut_b   <= w_vec[8:1];
      r_dut_cin <= w_vec[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pv[i] <= 1'b0;
        r_pk[i] <= '0;
        r_pe[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_issue;
      r_pk[0] <= w_k;
      r_pe[0] <= w_exp;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pk[i] <= r_pk[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  assign w_mis = r_pv[DEPTH-1] && ({dut_cout, dut_sum} != r_pe[DEPTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
      r_ffi <= NO_FAIL;
    end else if (w_accept) begin
      r_err <= '0;
      r_ffi <= NO_FAIL;
    end else if (w_mis) begin
      if (r_err != 16'hFFFF) begin
        r_err <= r_err + 16'd1;
      end
      if (r_ffi == NO_FAIL) begin
        r_ffi <= r_pk[DEPTH-1];
      end
    end
  end

  assign dut_a          = r_dut_a;
  assign dut_b          = r_dut_b;
  assign dut_cin        = r_dut_cin;
  assign busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done           = (r_state == ST_DONE);
  assign pass           = done && (r_err == '0);
  assign err_count      = r_err;
  assign first_fail_idx = r_ffi;

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboard bench: the bench plays a 2-stage adder with selectable faults and
// compares issued vectors and run verdicts against a behavioural model.
module tb_adder_bist;

  localparam int unsigned NV   = 100;
  localparam int unsigned LAT  = 2;
  localparam logic [16:0] SEED = 17'h1ACE5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  dut_a, dut_b, dut_sum;
  logic        dut_cin, dut_cout;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;

  always #5 clk = ~clk;

  adder_bist #(
    .NUM_VECTORS(NV),
    .DUT_LATENCY(LAT),
    .LFSR_SEED(SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dut_a          (dut_a),
    .dut_b          (dut_b),
    .dut_cin        (dut_cin),
    .dut_sum        (dut_sum),
    .dut_cout       (dut_cout),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx)
  );

  int          checks = 0;
  int          failures = 0;
  int          mode = 0;
  int          fbit = 0;
  logic [16:0] ftrig = '0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  bit          run_active = 0;
  logic        prev_done = 1'b0;

  typedef struct {
    int unsigned errs;
    int unsigned ffi;
    bit          ok;
  } res_t;

  logic [16:0] vq[$];
  res_t        rq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Adder behaviour including the selected fault; v = {A, B, Cin}.
  function automatic logic [8:0] adder_out(input logic [16:0] v);
    logic [8:0] r;
    r = {1'b0, v[16:9]} + {1'b0, v[8:1]} + {8'd0, v[0]};
    case (mode)
      1: r[8] = 1'b0;
      2: if (v[16:9] == 8'hF0 && v[8:1] == 8'hB0) r[0] = ~r[0];
      3: if (v[0] && v[9]) r[fbit] = ~r[fbit];
      5: if (v == ftrig) r[0] = ~r[0];
      default: ;
    endcase
    return r;
  endfunction

  // Two-register adder pipeline driven by the controller's operands.
  logic [8:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= adder_out({dut_a, dut_b, dut_cin});
    p2 <= p1;
  end
  assign {dut_cout, dut_sum} = p2;

  function automatic logic [16:0] vec_at(input int unsigned k);
    logic [16:0] dirv [4];
    logic [16:0] lf;
    dirv[0] = {8'hFF, 8'h01, 1'b0};
    dirv[1] = {8'hFF, 8'hFF, 1'b0};
    dirv[2] = {8'hFF, 8'hFF, 1'b1};
    dirv[3] = {8'h00, 8'h00, 1'b0};
    if (k < 4) return dirv[k];
    lf = SEED;
    for (int unsigned j = 4; j < k; j++) lf = {lf[15:0], lf[16] ^ lf[13]};
    return lf;
  endfunction

  task automatic model_run();
    int unsigned errs = 0;
    int unsigned ffi  = 16'hFFFF;
    logic [16:0] v;
    logic [8:0]  gold;
    res_t        r;
    for (int unsigned k = 0; k < NV; k++) begin
      v = vec_at(k);
      vq.push_back(v);
      gold = v[16:9] + v[8:1] + v[0];
      if (adder_out(v) != gold) begin
        errs++;
        if (ffi == 16'hFFFF) ffi = k;
      end
    end
    r.errs = (errs > 65535) ? 65535 : errs;
    r.ffi  = ffi;
    r.ok   = (errs == 0);
    rq.push_back(r);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a"},    {24'd0, dut_a}, 32'd0);
    check({tag, "_b"},    {24'd0, dut_b}, 32'd0);
    check({tag, "_cin"},  {31'd0, dut_cin}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_err"},  {16'd0, err_count}, 32'd0);
    check({tag, "_ffi"},  {16'd0, first_fail_idx}, 32'hFFFF);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_cyc  = cyc;
    run_active = 1;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done_drop", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (!done && n < NV + LAT + 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    run_active = 0;
  endtask

  // Monitor: checks issued vectors and the verdict when done rises.
  always @(negedge clk) begin
    int unsigned off;
    logic [16:0] ev;
    res_t        r;
    if (run_active && !rst) begin
      off = cyc - start_cyc;
      if (off < NV && vq.size() > 0) begin
        ev = vq.pop_front();
        check("vector", {15'd0, dut_a, dut_b, dut_cin}, {15'd0, ev});
      end
      if (done && !prev_done && rq.size() > 0) begin
        r = rq.pop_front();
        check("done_edge", off, NV + LAT + 1);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("err_count", {16'd0, err_count}, r.errs);
        check("first_fail_idx", {16'd0, first_fail_idx}, r.ffi);
        check("pass", {31'd0, pass}, {31'd0, r.ok});
      end
    end
    prev_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #3;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    // Correct adder.
    mode = 0;
    model_run();
    do_start();
    wait_done();

    // Cout stuck at zero; restart directly from DONE.
    mode = 1;
    model_run();
    do_start();
    wait_done();

    // Random sum/cout bit flipped whenever Cin and A[0] are both set.
    mode = 3;
    fbit = $urandom_range(8, 0);
    model_run();
    do_start();
    wait_done();

    // Sum[0] flip on the A=F0, B=B0 pair.
    mode = 2;
    model_run();
    do_start();
    wait_done();

    // Sum[0] flip on one randomly chosen random-phase vector.
    mode  = 5;
    ftrig = vec_at($urandom_range(NV - 1, 4));
    model_run();
    do_start();
    wait_done();

    // Spurious start mid-run must be ignored.
    mode = 3;
    fbit = $urandom_range(8, 0);
    model_run();
    do_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_busy", {31'd0, busy}, 32'd1);
    wait_done();

    // Reset mid-run, then a fresh run.
    mode = 1;
    model_run();
    do_start();
    repeat (20) @(posedge clk);
    #1;
    rst        = 1'b1;
    run_active = 0;
    vq.delete();
    rq.delete();
    #1;
    check_reset_vals("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("midrun_reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_run();
    do_start();
    wait_done();

    check("queues_drained", vq.size() + rq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
